l2_arbiter: RTL and testbench
=============================

L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, line address width.
REQ-002 Parameter: LINE_W, default 256, cache line data width.
REQ-003 Port: clk, input, 1, sole clock, rising edge.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: i_mem_read, input, 1, I-side line read request, held until i_mem_resp.
REQ-006 Port: i_mem_address, input, ADDR_W, I-side line address.
REQ-007 Port: i_mem_rdata / i_mem_resp, output, LINE_W / 1, I-side read line / one-cycle completion pulse.
REQ-008 Port: d_mem_read / d_mem_write, input, 1 / 1, D-side request, mutually exclusive, held until d_mem_resp.
REQ-009 Port: d_mem_address / d_mem_wdata, input, ADDR_W / LINE_W, D-side line address / write line.
REQ-010 Port: d_mem_rdata / d_mem_resp, output, LINE_W / 1, D-side read line / one-cycle completion pulse.
REQ-011 Port: l2_mem_read / l2_mem_write, output, 1 / 1, request to shared L2 controller.
REQ-012 Port: l2_mem_address / l2_mem_wdata, output, ADDR_W / LINE_W, L2 request address / write line.
REQ-013 Port: l2_mem_rdata / l2_mem_resp, input, LINE_W / 1, L2 read line / completion.

Function
REQ-014 States SHALL be IDLE, SERVE_I, SERVE_D; at most one requester owns L2 at any time.
REQ-015 IDLE: no L2 request SHALL be driven; if any request is present at a rising edge, the winner SHALL be granted and the state SHALL move to SERVE_I or SERVE_D.
REQ-016 On grant, address, read/write type and (D write) wdata SHALL be latched; L2 outputs SHALL be driven only from latched values, one cycle after the request is sampled.
REQ-017 SERVE_x: l2_mem_read/l2_mem_write SHALL be held constant until l2_mem_resp.
REQ-018 In the cycle l2_mem_resp=1, the owner's x_mem_resp SHALL be 1 (combinational), x_mem_rdata SHALL equal l2_mem_rdata, and next state SHALL be IDLE.
REQ-019 A non-owner's resp SHALL stay 0; a non-owner's rdata SHALL be 0.
REQ-020 Minimum gap between consecutive L2 transactions SHALL be one IDLE cycle.
REQ-021 If the owner deasserts its request before l2_mem_resp, the L2 transaction SHALL still complete; the resp pulse SHALL still be issued.
REQ-022 Requests arriving during SERVE_x SHALL wait; requests are never dropped and are never granted twice for one assertion.
REQ-023 l2_mem_resp while IDLE SHALL be ignored.
REQ-024 Simultaneous I and D requests SHALL be resolved per REQ-028/REQ-029.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE and clear latched address/data/type and the last-grant flag.
REQ-026 During and after reset, all outputs SHALL be 0 until the next grant.
REQ-027 Reset mid-transaction SHALL abandon it with no resp pulse; a subsequent stray l2_mem_resp SHALL be ignored per REQ-023.

Configuration
REQ-028 Macro L2_ARB_RR_EN defined: round-robin priority; on contention, the side not granted last wins; the last-grant flag resets to I, so D wins the first tie.
REQ-029 Macro L2_ARB_RR_EN undefined: fixed priority; D always wins contention; no last-grant flag exists.

Verification
REQ-030 Single I read at 0x0000_1000 with L2 resp after 3 cycles -> l2_mem_read high cycles 1-4, i_mem_resp pulse at cycle 4 carrying the L2 line, d_mem_resp stays 0.
REQ-031 D write at 0x0000_2040 with wdata 0xA5 pattern -> l2_mem_write=1, address and wdata match, d_mem_resp pulses once, l2_mem_read stays 0.
REQ-032 I and D requests in the same cycle, repeated back-to-back 4 times -> RR build: grants D,I,D,I with I and D alternating; fixed build: D served first in every contention.
REQ-033 I requester drops i_mem_read one cycle after grant -> l2_mem_read held until l2_mem_resp, single i_mem_resp pulse, then IDLE.
REQ-034 rst_n low mid SERVE_D, then l2_mem_resp=1 after release -> all outputs 0, no resp pulse, next request granted normally.
REQ-035 Request changes address after grant -> l2_mem_address keeps the grant-time value until resp.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 line port between the I-side and D-side requesters.
// Define L2_ARB_RR_EN for round-robin priority; otherwise D wins every contention.
module l2_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              l2_mem_read,
    output logic              l2_mem_write,
    output logic [ADDR_W-1:0] l2_mem_address,
    output logic [LINE_W-1:0] l2_mem_wdata,
    input  logic [LINE_W-1:0] l2_mem_rdata,
    input  logic              l2_mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              i_req, d_req, pick_d;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

`ifdef L2_ARB_RR_EN
    logic last_d_q, last_d_d;

    // On a tie the side that was not granted last goes first.
    assign pick_d = d_req & (~i_req | ~last_d_q);
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
`ifdef L2_ARB_RR_EN
        last_d_d = last_d_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = SERVE_D;
                    addr_d  = d_mem_address;
                    rd_d    = d_mem_read;
                    wr_d    = d_mem_write;
                    wdata_d = d_mem_write ? d_mem_wdata : '0;
`ifdef L2_ARB_RR_EN
                    last_d_d = 1'b1;
`endif
                end else if (i_req) begin
                    state_d = SERVE_I;
                    addr_d  = i_mem_address;
                    rd_d    = 1'b1;
                    wr_d    = 1'b0;
                    wdata_d = '0;
`ifdef L2_ARB_RR_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            SERVE_I, SERVE_D: begin
                // Completion returns to IDLE with the L2 port quiet again.
                if (l2_mem_resp) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    wdata_d = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

`ifdef L2_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`endif

    assign l2_mem_read    = rd_q;
    assign l2_mem_write   = wr_q;
    assign l2_mem_address = addr_q;
    assign l2_mem_wdata   = wdata_q;

    assign i_mem_resp  = (state_q == SERVE_I) & l2_mem_resp;
    assign d_mem_resp  = (state_q == SERVE_D) & l2_mem_resp;
    assign i_mem_rdata = {LINE_W{i_mem_resp}} & l2_mem_rdata;
    assign d_mem_rdata = {LINE_W{d_mem_resp}} & l2_mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: scoreboard bench for l2_arbiter with a simple L2 responder.
// Compile with +define+L2_ARB_RR_EN to check the round-robin build.
`timescale 1ns/1ps
module tb_l2_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_mem_read = 1'b0;
    logic [AW-1:0] i_mem_address = '0;
    logic [LW-1:0] i_mem_rdata;
    logic          i_mem_resp;
    logic          d_mem_read = 1'b0;
    logic          d_mem_write = 1'b0;
    logic [AW-1:0] d_mem_address = '0;
    logic [LW-1:0] d_mem_wdata = '0;
    logic [LW-1:0] d_mem_rdata;
    logic          d_mem_resp;
    logic          l2_mem_read;
    logic          l2_mem_write;
    logic [AW-1:0] l2_mem_address;
    logic [LW-1:0] l2_mem_wdata;
    logic [LW-1:0] l2_mem_rdata = '0;
    logic          l2_mem_resp = 1'b0;

    l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_mem_read(i_mem_read),
        .i_mem_address(i_mem_address),
        .i_mem_rdata(i_mem_rdata),
        .i_mem_resp(i_mem_resp),
        .d_mem_read(d_mem_read),
        .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address),
        .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata),
        .d_mem_resp(d_mem_resp),
        .l2_mem_read(l2_mem_read),
        .l2_mem_write(l2_mem_write),
        .l2_mem_address(l2_mem_address),
        .l2_mem_wdata(l2_mem_wdata),
        .l2_mem_rdata(l2_mem_rdata),
        .l2_mem_resp(l2_mem_resp)
    );

    always #5 clk = ~clk;

    wire [803:0] all_out = {l2_mem_read, l2_mem_write, l2_mem_address,
                            l2_mem_wdata, i_mem_resp, i_mem_rdata,
                            d_mem_resp, d_mem_rdata};

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } exp_t;

    exp_t i_q[$];
    exp_t d_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   m_last_d = 1'b0;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        r = '0;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic req_i(input logic [AW-1:0] a);
        exp_t e;
        i_mem_read = 1'b1;
        i_mem_address = a;
        e.wr = 1'b0;
        e.addr = a;
        e.wdata = '0;
        i_q.push_back(e);
    endtask

    task automatic req_d(input logic wr, input logic [AW-1:0] a,
                         input logic [LW-1:0] w);
        exp_t e;
        d_mem_read = ~wr;
        d_mem_write = wr;
        d_mem_address = a;
        d_mem_wdata = w;
        e.wr = wr;
        e.addr = a;
        e.wdata = w;
        d_q.push_back(e);
    endtask

    // Waits for a grant, checks it against the queued request of the
    // expected winner, holds for lat cycles, then completes it.
    task automatic serve(input int lat, input bit drop,
                         output bit sd, output bit ok);
        exp_t          e;
        logic [LW-1:0] rd;
        bit            ri, rq, seen, bad;
        ok = 1'b0;
        sd = 1'b0;
        seen = 1'b0;
        ri = 1'b0;
        rq = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            ri = i_mem_read;
            rq = d_mem_read | d_mem_write;
            step();
            seen = l2_mem_read | l2_mem_write;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL grant_wait: no L2 request within 40 cycles");
            return;
        end
`ifdef L2_ARB_RR_EN
        sd = rq && (!ri || !m_last_d);
`else
        sd = rq;
`endif
        n_chk++;
        if ((sd && d_q.size() == 0) || (!sd && i_q.size() == 0)) begin
            n_fail++;
            $display("FAIL grant_side: expected side d=%0b has no queued request", sd);
            return;
        end
        if (sd) e = d_q.pop_front();
        else e = i_q.pop_front();
        m_last_d = sd;
        n_chk++;
        if (l2_mem_address !== e.addr || l2_mem_read !== ~e.wr
            || l2_mem_write !== e.wr) begin
            n_fail++;
            $display("FAIL grant_req: addr=%h rd=%b wr=%b expected addr=%h rd=%b wr=%b",
                     l2_mem_address, l2_mem_read, l2_mem_write,
                     e.addr, ~e.wr, e.wr);
        end
        if (e.wr) begin
            n_chk++;
            if (l2_mem_wdata !== e.wdata) begin
                n_fail++;
                $display("FAIL grant_wdata: got %h expected %h",
                         l2_mem_wdata[31:0], e.wdata[31:0]);
            end
        end
        for (int j = 0; j < lat; j++) begin
            n_chk++;
            if (l2_mem_read !== ~e.wr || l2_mem_write !== e.wr
                || l2_mem_address !== e.addr
                || i_mem_resp !== 1'b0 || d_mem_resp !== 1'b0) begin
                n_fail++;
                $display("FAIL hold: cyc=%0d rd=%b wr=%b addr=%h iresp=%b dresp=%b expected addr=%h",
                         j, l2_mem_read, l2_mem_write, l2_mem_address,
                         i_mem_resp, d_mem_resp, e.addr);
            end
            if (j == 0 && drop) begin
                if (sd) begin
                    d_mem_read = 1'b0;
                    d_mem_write = 1'b0;
                end else begin
                    i_mem_read = 1'b0;
                end
            end else if (sd && (d_mem_read | d_mem_write)) begin
                d_mem_address = $urandom;
            end else if (!sd && i_mem_read) begin
                i_mem_address = $urandom;
            end
            step();
        end
        rd = rand_line();
        l2_mem_rdata = rd;
        l2_mem_resp = 1'b1;
        #1;
        n_chk++;
        if (sd) bad = d_mem_resp !== 1'b1 || d_mem_rdata !== rd
                      || i_mem_resp !== 1'b0 || i_mem_rdata !== '0;
        else bad = i_mem_resp !== 1'b1 || i_mem_rdata !== rd
                   || d_mem_resp !== 1'b0 || d_mem_rdata !== '0;
        if (bad) begin
            n_fail++;
            $display("FAIL resp: iresp=%b drep=%b irdata=%h drdata=%h expected owner_d=%b rdata=%h",
                     i_mem_resp, d_mem_resp, i_mem_rdata[31:0],
                     d_mem_rdata[31:0], sd, rd[31:0]);
        end
        step();
        l2_mem_resp = 1'b0;
        l2_mem_rdata = '0;
        if (sd) begin
            d_mem_read = 1'b0;
            d_mem_write = 1'b0;
        end else begin
            i_mem_read = 1'b0;
        end
        #1;
        n_chk++;
        if ({l2_mem_read, l2_mem_write, i_mem_resp, d_mem_resp} !== 4'b0) begin
            n_fail++;
            $display("FAIL post_idle: rd=%b wr=%b iresp=%b dresp=%b expected 0",
                     l2_mem_read, l2_mem_write, i_mem_resp, d_mem_resp);
        end
        ok = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_chk++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h expected 0", all_out);
        end
        rst_n = 1'b1;
        step();
        l2_mem_resp = 1'b1;
        l2_mem_rdata = rand_line();
        #1;
        n_chk++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL idle_stray_resp: outputs=%h expected 0", all_out);
        end
        step();
        l2_mem_resp = 1'b0;
        l2_mem_rdata = '0;
    endtask

    task automatic test_single_i();
        bit sd, ok;
        req_i(32'h0000_1000);
        serve(3, 1'b0, sd, ok);
    endtask

    task automatic test_d_write();
        bit sd, ok;
        req_d(1'b1, 32'h0000_2040, {32{8'hA5}});
        serve(2, 1'b0, sd, ok);
    endtask

    task automatic test_drop_early();
        bit sd, ok;
        req_i(32'h0000_1100);
        serve(3, 1'b1, sd, ok);
        step();
        n_chk++;
        if ({l2_mem_read, l2_mem_write, i_mem_resp} !== 3'b0) begin
            n_fail++;
            $display("FAIL drop_idle: rd=%b wr=%b iresp=%b expected 0",
                     l2_mem_read, l2_mem_write, i_mem_resp);
        end
    endtask

    task automatic test_addr_hold();
        bit sd, ok;
        req_d(1'b0, 32'h0000_7040, '0);
        serve(5, 1'b0, sd, ok);
    endtask

    task automatic test_reset_mid();
        bit sd, ok, seen;
        req_d(1'b1, 32'h0000_5000, rand_line());
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            step();
            seen = l2_mem_write;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_grant_wait: no L2 write within 10 cycles");
        end
        step();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_async: outputs=%h expected 0", all_out);
        end
        d_mem_write = 1'b0;
        d_q.delete();
        i_q.delete();
        m_last_d = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        l2_mem_resp = 1'b1;
        l2_mem_rdata = rand_line();
        for (int c = 0; c < 2; c++) begin
            #1;
            n_chk++;
            if (all_out !== '0) begin
                n_fail++;
                $display("FAIL rst_stray_resp: cyc=%0d outputs=%h expected 0",
                         c, all_out);
            end
            step();
        end
        l2_mem_resp = 1'b0;
        l2_mem_rdata = '0;
        req_i(32'h0000_6000);
        serve(2, 1'b0, sd, ok);
    endtask

    task automatic test_back_to_back();
        bit       sd, ok;
        bit [3:0] seq, exp_seq;
        seq = '0;
        req_i(32'h0000_3000);
        req_d(1'b0, 32'h0000_4000, '0);
        for (int k = 0; k < 4; k++) begin
            serve(2, 1'b0, sd, ok);
            if (!ok) return;
            seq[k] = sd;
            if (sd) req_d(k[0], AW'(32'h4000 + 64 * (k + 1)), rand_line());
            else req_i(AW'(32'h3000 + 64 * (k + 1)));
        end
`ifdef L2_ARB_RR_EN
        exp_seq = 4'b0101;
`else
        exp_seq = 4'b1111;
`endif
        n_chk++;
        if (seq !== exp_seq) begin
            n_fail++;
            $display("FAIL contention_order: grants(d=1,first=lsb)=%b expected %b",
                     seq, exp_seq);
        end
        for (int k = 0; k < 2; k++) begin
            serve(2, 1'b0, sd, ok);
            if (!ok) return;
        end
        n_chk++;
        if (i_q.size() != 0 || d_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending i=%0d d=%0d expected 0 0",
                     i_q.size(), d_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_i();
        test_d_write();
        test_drop_early();
        test_addr_hold();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
